// File: rtl/decode_issue_stage.sv
// Decode/issue stage: splits instructions, reads operands from the register file and
// issues them to execute, stalling on RAW/WAW hazards tracked by a pending-write scoreboard.
module decode_issue_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clock_enable,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0]            in_instr,
    output logic [2:0]             reg_read_addr_1,
    output logic [2:0]             reg_read_addr_2,
    input  logic [15:0]            reg_read_data_1,
    input  logic [15:0]            reg_read_data_2,
    input  logic                   wb_en,
    input  logic [2:0]             wb_dest,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_op,
    output logic [2:0]             out_rd,
    output logic                   out_wr,
    output logic [15:0]            out_a,
    output logic [15:0]            out_b,
    output logic [15:0]            out_imm,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic [3:0] op;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic [5:0] imm6;

    assign op   = in_instr[15:12];
    assign rs1  = in_instr[11:9];
    assign rs2  = in_instr[8:6];
    assign rd   = in_instr[5:3];
    assign imm6 = in_instr[5:0];

    assign reg_read_addr_1 = rs1;
    assign reg_read_addr_2 = rs2;

    logic dec_reads_1;
    logic dec_reads_2;
    logic dec_wr;

    always_comb begin
        dec_reads_1 = 1'b0;
        dec_reads_2 = 1'b0;
        dec_wr      = 1'b0;
        if (op <= 4'h7) begin
            dec_reads_1 = 1'b1;
            dec_reads_2 = 1'b1;
            dec_wr      = 1'b1;
        end else begin
            case (op)
                4'h8: begin
                    dec_reads_1 = 1'b1;
                    dec_wr      = 1'b1;
                end
                4'h9, 4'hA, 4'hB: begin
                    dec_reads_1 = 1'b1;
                    dec_reads_2 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic [7:0]             pending_reg;
    logic [7:0]             pending_next;
    logic                   out_valid_reg;
    logic [3:0]             out_op_reg;
    logic [2:0]             out_rd_reg;
    logic                   out_wr_reg;
    logic [15:0]            out_a_reg;
    logic [15:0]            out_b_reg;
    logic [15:0]            out_imm_reg;
    logic [STALL_CNT_W-1:0] stall_cycles_reg;

    // Writeback clears do not bypass: a register being written this cycle still stalls.
    logic hazard;
    assign hazard = in_valid & ((dec_reads_1 & pending_reg[rs1]) |
                                (dec_reads_2 & pending_reg[rs2]) |
                                (dec_wr      & pending_reg[rd]));

    assign in_ready = clock_enable & ~flush & ~hazard & (~out_valid_reg | out_ready);

    logic accept;
    assign accept = in_valid & in_ready;

    logic flush_held_wr;
    assign flush_held_wr = flush & out_valid_reg & out_wr_reg;

    // Per-register scoreboard bit; a set on the same edge as a clear wins.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pending
        logic set_bit;
        logic clr_bit;
        assign set_bit = accept & dec_wr & (rd == 3'(gi));
        assign clr_bit = (wb_en & (wb_dest == 3'(gi))) |
                         (flush_held_wr & (out_rd_reg == 3'(gi)));
        assign pending_next[gi] = set_bit | (pending_reg[gi] & ~clr_bit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
        end else if (clock_enable) begin
            pending_reg <= pending_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_op_reg    <= '0;
            out_rd_reg    <= '0;
            out_wr_reg    <= 1'b0;
            out_a_reg     <= '0;
            out_b_reg     <= '0;
            out_imm_reg   <= '0;
        end else if (clock_enable) begin
            if (flush) begin
                out_valid_reg <= 1'b0;
            end else if (accept) begin
                out_valid_reg <= 1'b1;
                out_op_reg    <= op;
                out_rd_reg    <= rd;
                out_wr_reg    <= dec_wr;
                out_a_reg     <= reg_read_data_1;
                out_b_reg     <= reg_read_data_2;
                out_imm_reg   <= {{10{imm6[5]}}, imm6};
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_reg <= '0;
        end else if (clock_enable & hazard & ~(&stall_cycles_reg)) begin
            stall_cycles_reg <= stall_cycles_reg + 1'b1;
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_op       = out_op_reg;
    assign out_rd       = out_rd_reg;
    assign out_wr       = out_wr_reg;
    assign out_a        = out_a_reg;
    assign out_b        = out_b_reg;
    assign out_imm      = out_imm_reg;
    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed stimulus pushes expected issues into a queue,
// a monitor pops and compares on every output transfer.
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        clock_enable;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [2:0]  reg_read_addr_1;
    logic [2:0]  reg_read_addr_2;
    logic [15:0] reg_read_data_1;
    logic [15:0] reg_read_data_2;
    logic        wb_en;
    logic [2:0]  wb_dest;
    logic [15:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [2:0]  out_rd;
    logic        out_wr;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [15:0] out_imm;
    logic [15:0] stall_cycles;

    int compared   = 0;
    int mismatched = 0;
    logic [55:0] exp_q[$];
    logic [15:0] regs[8];

    always #5 clk = ~clk;

    decode_issue_stage #(.STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .clock_enable(clock_enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .reg_read_addr_1(reg_read_addr_1), .reg_read_addr_2(reg_read_addr_2),
        .reg_read_data_1(reg_read_data_1), .reg_read_data_2(reg_read_data_2),
        .wb_en(wb_en), .wb_dest(wb_dest), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_rd(out_rd), .out_wr(out_wr), .out_a(out_a), .out_b(out_b),
        .out_imm(out_imm), .stall_cycles(stall_cycles)
    );

    // Register file model: initial contents while in reset, written by the writeback port.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'(i * 16'h0011);
            regs[1] <= 16'h0005;
            regs[2] <= 16'h0007;
        end else if (wb_en) begin
            regs[wb_dest] <= wb_data;
        end
    end
    assign reg_read_data_1 = regs[reg_read_addr_1];
    assign reg_read_data_2 = regs[reg_read_addr_2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [55:0] mk(input logic [3:0] op, input logic [2:0] rd, input logic wr,
                                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm);
        return {op, rd, wr, a, b, imm};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && clock_enable && !flush) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 64'(out_op), 64'hFFFF_FFFF);
            end else begin
                logic [55:0] e;
                e = exp_q.pop_front();
                $display("issue op=%h rd=%0d wr=%0d a=%h b=%h imm=%h (expected %h)",
                         out_op, out_rd, out_wr, out_a, out_b, out_imm, e);
                check("issue", 64'({out_op, out_rd, out_wr, out_a, out_b, out_imm}), 64'(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] instr, input logic [55:0] e, input int budget,
                         output int waited);
        bit done;
        done   = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        in_instr = instr;
        while (!done && waited <= budget) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
            step();
            if (!done) waited++;
        end
        in_valid = 1'b0;
        check("issue_accepted", 64'(done), 64'd1);
    endtask

    task automatic wb(input logic [2:0] dest, input logic [15:0] data);
        wb_en   = 1'b1;
        wb_dest = dest;
        wb_data = data;
        step();
        wb_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst = 1'b1; clock_enable = 1'b1; in_valid = 1'b0; in_instr = 16'h0;
        wb_en = 1'b0; wb_dest = 3'd0; wb_data = 16'h0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_pending", 64'(dut.pending_reg), 64'h00);
        check("rst_stall", 64'(stall_cycles), 64'd0);
        check("rst_outputs", 64'({out_op, out_rd, out_wr, out_a, out_b, out_imm}), 64'd0);
        step();
        rst = 1'b0;
        step();

        // T1: plain ALU issue
        issue(16'h0298, mk(4'h0, 3'd3, 1'b1, 16'h0005, 16'h0007, 16'h0018), 2, waited);
        @(negedge clk);
        check("t1_pending", 64'(dut.pending_reg), 64'h08);
        check("t1_addr", 64'({reg_read_addr_1, reg_read_addr_2}), 64'({3'd1, 3'd2}));
        step();

        // T2: RAW on R3, released one cycle after the writeback
        in_valid = 1'b1;
        in_instr = 16'h1660;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_stall_ready", 64'(in_ready), 64'd0);
            step();
        end
        check("t2_stall_count3", 64'(stall_cycles), 64'd3);
        wb_en = 1'b1; wb_dest = 3'd3; wb_data = 16'h0A0A;
        @(negedge clk);
        check("t2_wb_cycle_ready", 64'(in_ready), 64'd0);
        step();
        wb_en = 1'b0;
        check("t2_stall_count4", 64'(stall_cycles), 64'd4);
        issue(16'h1660, mk(4'h1, 3'd4, 1'b1, 16'h0A0A, 16'h0005, 16'hFFE0), 2, waited);
        check("t2_accept_wait", 64'(waited), 64'd0);
        @(negedge clk);
        step();

        // T3: backpressure then back-to-back issue
        out_ready = 1'b0;
        issue(16'h02B0, mk(4'h0, 3'd6, 1'b1, 16'h0005, 16'h0007, 16'hFFF0), 2, waited);
        in_valid = 1'b1;
        in_instr = 16'h0478;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_hold_ready", 64'(in_ready), 64'd0);
            check("t3_hold_out", 64'({out_valid, out_a, out_rd}), 64'({1'b1, 16'h0005, 3'd6}));
            step();
        end
        check("t3_no_hazard_stall", 64'(stall_cycles), 64'd4);
        out_ready = 1'b1;
        issue(16'h0478, mk(4'h0, 3'd7, 1'b1, 16'h0007, 16'h0005, 16'hFFF8), 0, waited);
        check("t3_b2b_1", 64'(waited), 64'd0);
        issue(16'hD000, mk(4'hD, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000), 0, waited);
        check("t3_b2b_2", 64'(waited), 64'd0);
        @(negedge clk);
        check("t3_pending", 64'(dut.pending_reg), 64'hD0);
        step();
        wb(3'd4, 16'h0044);
        wb(3'd6, 16'h0066);
        wb(3'd7, 16'h0077);
        @(negedge clk);
        check("t3_pending_clear", 64'(dut.pending_reg), 64'h00);
        step();

        // T4: flush of a held LOAD
        out_ready = 1'b0;
        issue(16'h8228, mk(4'h8, 3'd5, 1'b1, 16'h0005, 16'h0000, 16'hFFE8), 2, waited);
        @(negedge clk);
        check("t4_pending_set", 64'({out_valid, dut.pending_reg}), 64'({1'b1, 8'h20}));
        step();
        flush = 1'b1; in_valid = 1'b1; in_instr = 16'hD000;
        @(negedge clk);
        check("t4_flush_ready", 64'(in_ready), 64'd0);
        void'(exp_q.pop_back());
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("t4_after_flush", 64'({out_valid, dut.pending_reg}), 64'({1'b0, 8'h00}));
        step();

        // T5: clock_enable low while an instruction is held
        issue(16'h0298, mk(4'h0, 3'd3, 1'b1, 16'h0005, 16'h0007, 16'h0018), 2, waited);
        clock_enable = 1'b0; out_ready = 1'b1;
        wb_en = 1'b1; wb_dest = 3'd3; wb_data = 16'h0A0A;
        in_valid = 1'b1; in_instr = 16'h1660;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t5_ready", 64'(in_ready), 64'd0);
            check("t5_state", 64'({out_valid, dut.pending_reg, stall_cycles}),
                  64'({1'b1, 8'h08, 16'd4}));
            step();
        end
        clock_enable = 1'b1; wb_en = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        step();
        wb(3'd3, 16'h0A0A);
        @(negedge clk);
        check("t5_pending_clear", 64'({out_valid, dut.pending_reg, stall_cycles}),
              64'({1'b0, 8'h00, 16'd4}));
        step();

        // T6: asynchronous reset mid-cycle, then sign-extended immediate
        out_ready = 1'b0;
        issue(16'h02B0, mk(4'h0, 3'd6, 1'b1, 16'h0005, 16'h0007, 16'hFFF0), 2, waited);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_rst", 64'({out_valid, dut.pending_reg, stall_cycles}), 64'd0);
        check("t6_rst_outputs", 64'({out_op, out_rd, out_wr, out_a}), 64'd0);
        exp_q.delete();
        step();
        rst = 1'b0; out_ready = 1'b1;
        issue(16'hD03F, mk(4'hD, 3'd7, 1'b0, 16'h0000, 16'h0000, 16'hFFFF), 2, waited);
        @(negedge clk);
        step();
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
